// File: rtl/serial_add_if.sv
// Bundles the serial adder's request/result signals and its link to the
// external 1-bit full-adder cell.
interface serial_add_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             fa_a;
   logic             fa_b;
   logic             fa_c;
   logic             fa_s;
   logic             fa_co;

   // The master drives requests and also stands in for the adder cell.
   modport master (
      output start, op_a, op_b, cin, fa_s, fa_co,
      input  busy, done, sum, cout, ovf, fa_a, fa_b, fa_c
   );

   modport slave (
      input  start, op_a, op_b, cin, fa_s, fa_co,
      output busy, done, sum, cout, ovf, fa_a, fa_b, fa_c
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial sequencer around an external 1-bit full adder, LSB first.
// Define SERIAL_ADD_OVF_EN to build signed-overflow detection; otherwise ovf is 0.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input logic        clk,
   input logic        rst,
   serial_add_if.slave bus
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q, cout_q;
   logic [CntW-1:0]  cnt_q;
   logic             accept, shift_en, last;

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      shift_en = 1'b0;
      last     = (cnt_q == CntW'(WIDTH - 1));
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            shift_en = 1'b1;
            if (last) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         a_q     <= bus.op_a;
         b_q     <= bus.op_b;
         carry_q <= bus.cin;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (shift_en) begin
         sum_q   <= {bus.fa_s, sum_q[WIDTH-1:1]};
         carry_q <= bus.fa_co;
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         // Counter returns to 0 after the last bit rather than running past WIDTH-1.
         cnt_q   <= last ? '0 : cnt_q + CntW'(1);
         if (last) cout_q <= bus.fa_co;
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_q;

   // Carry into the MSB xor carry out of the MSB.
   always_ff @(posedge clk) begin
      if (rst || accept)        ovf_q <= 1'b0;
      else if (shift_en && last) ovf_q <= carry_q ^ bus.fa_co;
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.busy = (state_q == StShift);
   assign bus.done = (state_q == StDone);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.fa_a = shift_en & a_q[0];
   assign bus.fa_b = shift_en & b_q[0];
   assign bus.fa_c = shift_en & carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural full-adder cell.
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   serial_add_if #(.WIDTH(8)) bus ();

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.fa_s  = bus.fa_a ^ bus.fa_b ^ bus.fa_c;
   assign bus.fa_co = (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_c) | (bus.fa_b & bus.fa_c);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.op_a = 8'h00;
      bus.op_b = 8'h00;
      bus.cin = 1'b0;
      step();
      step();
      rst = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
      checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
      checks++;
      if ({bus.fa_a, bus.fa_b, bus.fa_c} !== 3'b000) begin
         errors++; $display("FAIL reset_fa got=%b exp=000", {bus.fa_a, bus.fa_b, bus.fa_c});
      end
      step();
   endtask

   // One full addition from accept to done, checking every bit cycle.
   task automatic test_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [7:0] es, input logic ec, input logic eo,
                           input string name);
      logic eovf;
`ifdef SERIAL_ADD_OVF_EN
      eovf = eo;
`else
      eovf = 1'b0;
`endif
      bus.op_a = a;
      bus.op_b = b;
      bus.cin = c;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.op_a = 8'h00;
      bus.op_b = 8'h00;
      bus.cin = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL %s_busy bit=%0d got busy=%b done=%b exp busy=1 done=0",
                               name, i, bus.busy, bus.done);
         end
         checks++;
         if (bus.fa_a !== a[i] || bus.fa_b !== b[i]) begin
            errors++; $display("FAIL %s_fa bit=%0d got a=%b b=%b exp a=%b b=%b",
                               name, i, bus.fa_a, bus.fa_b, a[i], b[i]);
         end
         if (i == 0) begin
            checks++;
            if (bus.fa_c !== c) begin
               errors++; $display("FAIL %s_fa_c0 got=%b exp=%b", name, bus.fa_c, c);
            end
         end
         step();
      end
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL %s_done got done=%b busy=%b exp done=1 busy=0",
                            name, bus.done, bus.busy);
      end
      checks++; if (bus.sum !== es) begin errors++; $display("FAIL %s_sum got=%h exp=%h", name, bus.sum, es); end
      checks++; if (bus.cout !== ec) begin errors++; $display("FAIL %s_cout got=%b exp=%b", name, bus.cout, ec); end
      checks++; if (bus.ovf !== eovf) begin errors++; $display("FAIL %s_ovf got=%b exp=%b", name, bus.ovf, eovf); end
      checks++;
      if (bus.fa_a !== 1'b0 || bus.fa_c !== 1'b0) begin
         errors++; $display("FAIL %s_fa_idle got a=%b c=%b exp 0", name, bus.fa_a, bus.fa_c);
      end
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.sum !== es) begin
         errors++; $display("FAIL %s_after got done=%b sum=%h exp done=0 sum=%h",
                            name, bus.done, bus.sum, es);
      end
   endtask

   task automatic test_ignore_start();
      bit seen;
      bus.op_a = 8'h10;
      bus.op_b = 8'h20;
      bus.cin = 1'b0;
      bus.start = 1'b1;
      step();                                   // E0
      bus.start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 3 || k == 8) begin
            bus.op_a = 8'hFF;
            bus.op_b = 8'hFF;
            bus.cin = 1'b1;
            bus.start = 1'b1;
         end
         step();
         bus.start = 1'b0;
         if (k == 3) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
               errors++; $display("FAIL ign_mid got busy=%b done=%b exp busy=1 done=0",
                                  bus.busy, bus.done);
            end
         end
      end
      checks++;
      if (bus.done !== 1'b1 || bus.sum !== 8'h30 || bus.cout !== 1'b0) begin
         errors++; $display("FAIL ign_done got done=%b sum=%h cout=%b exp done=1 sum=30 cout=0",
                            bus.done, bus.sum, bus.cout);
      end
      // Request raised right after the done pulse; must be taken once back in IDLE.
      bus.op_a = 8'h01;
      bus.op_b = 8'h02;
      bus.cin = 1'b0;
      bus.start = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
         step();
         if (k == 0) begin
            checks++;
            if (bus.done !== 1'b0) begin
               errors++; $display("FAIL ign_pulse_width got done=%b exp=0", bus.done);
            end
         end
         if (bus.busy === 1'b1) seen = 1'b1;
      end
      bus.start = 1'b0;
      checks++;
      if (!seen) begin
         errors++; $display("FAIL ign_restart got busy=0 exp busy=1 within 4 cycles");
      end else begin
         for (int k = 0; k < 8; k++) step();
         checks++;
         if (bus.done !== 1'b1 || bus.sum !== 8'h03) begin
            errors++; $display("FAIL ign_restart_sum got done=%b sum=%h exp done=1 sum=03",
                               bus.done, bus.sum);
         end
      end
      step();
   endtask

   task automatic test_reset_mid();
      int dones;
      bus.op_a = 8'hAA;
      bus.op_b = 8'h55;
      bus.cin = 1'b0;
      bus.start = 1'b1;
      step();                                   // E0
      bus.start = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();                                   // E0+4
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++; $display("FAIL rst_mid_ctrl got busy=%b done=%b exp 0 0", bus.busy, bus.done);
      end
      checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL rst_mid_sum got=%h exp=00", bus.sum); end
      checks++;
      if ({bus.fa_a, bus.fa_b, bus.fa_c} !== 3'b000) begin
         errors++; $display("FAIL rst_mid_fa got=%b exp=000", {bus.fa_a, bus.fa_b, bus.fa_c});
      end
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++; $display("FAIL rst_mid_quiet got active_cycles=%0d exp=0", dones);
      end
      test_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "rst_fresh");
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got no finish exp finish before 200000");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0;
      bus.op_a = 8'h00;
      bus.op_b = 8'h00;
      bus.cin = 1'b0;
      test_reset();
      test_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "basic");
      test_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap");
      test_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "cin");
      test_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_pos");
      test_add(8'hA5, 8'hC3, 1'b1, 8'h69, 1'b1, 1'b1, "ovf_neg");
      test_ignore_start();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
